// File: rtl/packet_mem_pkg.sv
// Shared types and pointer/space helpers for the packet buffer.
package packet_mem_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_CHECK,
        W_DROP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_PRIME,
        R_STREAM
    } rd_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_ERR,
        CAUSE_OVF,
        CAUSE_LEN
    } drop_cause_t;

    // Circular advance; depth need not be a power of two.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

    // Words still writable given committed usage and the frame in progress.
    function automatic int unsigned free_words(input int unsigned depth,
                                               input int unsigned used,
                                               input int unsigned len_cnt);
        return depth - used - len_cnt;
    endfunction

endpackage

// File: rtl/fifo.sv
// Show-ahead FIFO: o_rdata presents the head entry whenever o_empty is low.
module fifo #(
    parameter int unsigned pBITS  = 8,
    parameter int unsigned pWIDHT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic             i_rd,
    input  logic [pBITS-1:0] i_wdata,
    output logic [pBITS-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);

    localparam int unsigned PW = (pWIDHT > 1) ? $clog2(pWIDHT) : 1;
    localparam int unsigned CW = $clog2(pWIDHT + 1);

    logic [pBITS-1:0] r_mem [pWIDHT];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_wr && !o_full;
    assign w_pop   = i_rd && !o_empty;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(pWIDHT));
    assign o_rdata = r_mem[r_rptr];

    // Storage array, written on accepted pushes.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PW'(pWIDHT - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PW'(pWIDHT - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/reg_file.sv
// Simple dual-port RAM: one write port, one registered read port.
module reg_file #(
    parameter int unsigned pDATA_WIDTH = 8,
    parameter int unsigned pDEPTH      = 16,
    parameter int unsigned pADDR_WIDTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_we,
    input  logic [pADDR_WIDTH-1:0] i_waddr,
    input  logic [pDATA_WIDTH-1:0] i_wdata,
    input  logic                   i_re,
    input  logic [pADDR_WIDTH-1:0] i_raddr,
    output logic [pDATA_WIDTH-1:0] o_rdata
);

    logic [pDATA_WIDTH-1:0] r_mem [pDEPTH];

    // Write port.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port with one cycle of latency.
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/packet_buffer_mem.sv
// Store-and-forward packet buffer: frames are written into a circular RAM,
// committed only when clean and legal, and streamed out on request.
module packet_buffer_mem
    import packet_mem_pkg::*;
#(
    parameter int unsigned pDATA_WIDTH        = 8,
    parameter int unsigned pMIN_PACKET_LENGTH = 64,
    parameter int unsigned pMAX_PACKET_LENGTH = 1536,
    parameter int unsigned pDEPTH_RAM         = 2 * pMAX_PACKET_LENGTH,
    parameter int unsigned pFIFO_DEPTH        = pDEPTH_RAM / pMIN_PACKET_LENGTH,
    parameter int unsigned pLEN_WIDTH         = $clog2(pMAX_PACKET_LENGTH + 1)
) (
    input  logic                   iclk,
    input  logic                   i_rst,
    input  logic                   idv,
    input  logic [pDATA_WIDTH-1:0] irx_d,
    input  logic                   i_error,
    input  logic                   i_rd_start,
    output logic [pDATA_WIDTH-1:0] o_data,
    output logic                   o_dv,
    output logic                   o_last,
    output logic                   o_pkt_avail,
    output logic [pLEN_WIDTH-1:0]  o_pkt_len,
    output logic                   o_rd_busy,
    output logic                   o_drop_err,
    output logic                   o_drop_len,
    output logic                   o_drop_ovf
);

    localparam int unsigned AW = (pDEPTH_RAM > 1) ? $clog2(pDEPTH_RAM) : 1;
    localparam int unsigned CW = $clog2(pDEPTH_RAM + 1);
    localparam logic [pLEN_WIDTH-1:0] LEN_MAX = pLEN_WIDTH'(pMAX_PACKET_LENGTH);
    localparam logic [pLEN_WIDTH-1:0] LEN_MIN = pLEN_WIDTH'(pMIN_PACKET_LENGTH);

    // Write side
    wr_state_t             r_wr_state;
    wr_state_t             w_wr_next;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_commit_ptr;
    logic [pLEN_WIDTH-1:0] r_len_cnt;
    logic [CW-1:0]         r_used;
    logic [CW-1:0]         w_free;
    logic                  w_we;
    logic                  w_commit;
    logic                  w_drop;
    drop_cause_t           w_cause;
    logic                  r_drop_err;
    logic                  r_drop_len;
    logic                  r_drop_ovf;

    // Read side
    rd_state_t             r_rd_state;
    rd_state_t             w_rd_next;
    logic [AW-1:0]         r_rd_ptr;
    logic [pLEN_WIDTH-1:0] r_rd_cnt;
    logic [pLEN_WIDTH-1:0] r_rel_len;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_issue_last;
    logic                  r_ram_v;
    logic                  r_ram_last;
    logic                  w_release;
    logic [pDATA_WIDTH-1:0] w_ram_q;
    logic [pDATA_WIDTH-1:0] r_data;
    logic                  r_dv;
    logic                  r_last;

    // Length queue
    logic [pLEN_WIDTH-1:0] w_fifo_head;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;

    assign w_free = CW'(free_words(pDEPTH_RAM, 32'(r_used), 32'(r_len_cnt)));

    fifo #(
        .pBITS  (pLEN_WIDTH),
        .pWIDHT (pFIFO_DEPTH)
    ) u_len_fifo (
        .i_clk   (iclk),
        .i_rst   (i_rst),
        .i_wr    (w_commit),
        .i_rd    (w_accept),
        .i_wdata (r_len_cnt),
        .o_rdata (w_fifo_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    reg_file #(
        .pDATA_WIDTH (pDATA_WIDTH),
        .pDEPTH      (pDEPTH_RAM),
        .pADDR_WIDTH (AW)
    ) u_data_ram (
        .i_clk   (iclk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (irx_d),
        .i_re    (w_issue),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_q)
    );

    // Write FSM state register; a frame already in flight at reset is skipped silently.
    always_ff @(posedge iclk) begin
        if (i_rst) begin
            r_wr_state <= idv ? W_DROP : W_IDLE;
        end else begin
            r_wr_state <= w_wr_next;
        end
    end

    // Write FSM next-state logic.
    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            W_IDLE: begin
                if (idv) begin
                    w_wr_next = w_drop ? W_DROP : W_DATA;
                end
            end
            W_DATA: begin
                if (!idv) begin
                    w_wr_next = W_CHECK;
                end else if (w_drop) begin
                    w_wr_next = W_DROP;
                end
            end
            W_CHECK: w_wr_next = W_IDLE;
            W_DROP: begin
                if (!idv) begin
                    w_wr_next = W_IDLE;
                end
            end
            default: w_wr_next = W_IDLE;
        endcase
    end

    // Write FSM outputs: per-word write/drop decision and end-of-frame verdict, highest-priority cause first.
    always_comb begin
        w_we     = 1'b0;
        w_commit = 1'b0;
        w_cause  = CAUSE_NONE;
        if ((r_wr_state == W_IDLE || r_wr_state == W_DATA) && idv) begin
            if (i_error) begin
                w_cause = CAUSE_ERR;
            end else if (w_free == '0) begin
                w_cause = CAUSE_OVF;
            end else if (r_len_cnt == LEN_MAX) begin
                w_cause = CAUSE_LEN;
            end
            w_we = (w_cause == CAUSE_NONE);
        end else if (r_wr_state == W_CHECK) begin
            if (i_error) begin
                w_cause = CAUSE_ERR;
            end else if (w_fifo_full) begin
                w_cause = CAUSE_OVF;
            end else if (r_len_cnt < LEN_MIN) begin
                w_cause = CAUSE_LEN;
            end
            w_commit = (w_cause == CAUSE_NONE);
        end
        w_drop = (w_cause != CAUSE_NONE);
    end

    // Write pointers, frame length and committed usage; a drop rewinds to the last commit point.
    always_ff @(posedge iclk) begin
        if (i_rst) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_len_cnt    <= '0;
            r_used       <= '0;
        end else begin
            if (w_we) begin
                r_wr_ptr  <= AW'(next_ptr(32'(r_wr_ptr), pDEPTH_RAM));
                r_len_cnt <= r_len_cnt + 1'b1;
            end
            if (w_drop) begin
                r_wr_ptr  <= r_commit_ptr;
                r_len_cnt <= '0;
            end
            if (w_commit) begin
                r_commit_ptr <= r_wr_ptr;
                r_len_cnt    <= '0;
            end
            r_used <= r_used + (w_commit ? CW'(r_len_cnt) : '0)
                             - (w_release ? CW'(r_rel_len) : '0);
        end
    end

    // Registered one-cycle drop-cause pulses.
    always_ff @(posedge iclk) begin
        if (i_rst) begin
            r_drop_err <= 1'b0;
            r_drop_len <= 1'b0;
            r_drop_ovf <= 1'b0;
        end else begin
            r_drop_err <= (w_cause == CAUSE_ERR);
            r_drop_len <= (w_cause == CAUSE_LEN);
            r_drop_ovf <= (w_cause == CAUSE_OVF);
        end
    end

    // Read FSM state register.
    always_ff @(posedge iclk) begin
        if (i_rst) begin
            r_rd_state <= R_IDLE;
        end else begin
            r_rd_state <= w_rd_next;
        end
    end

    // Read FSM next-state logic; R_STREAM holds one extra cycle while the last word drains the RAM stage.
    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            R_IDLE: begin
                if (w_accept) begin
                    w_rd_next = R_PRIME;
                end
            end
            R_PRIME: w_rd_next = R_STREAM;
            R_STREAM: begin
                if (r_rd_cnt == '0) begin
                    w_rd_next = R_IDLE;
                end
            end
            default: w_rd_next = R_IDLE;
        endcase
    end

    // Read FSM outputs: start acceptance and RAM read issue.
    always_comb begin
        w_accept     = (r_rd_state == R_IDLE) && i_rd_start && !w_fifo_empty;
        w_issue      = (r_rd_state == R_PRIME || r_rd_state == R_STREAM) && (r_rd_cnt != '0);
        w_issue_last = w_issue && (r_rd_cnt == pLEN_WIDTH'(1));
    end

    // Read pointer, remaining-word count and the two-stage output pipeline (RAM, then o_data).
    always_ff @(posedge iclk) begin
        if (i_rst) begin
            r_rd_ptr   <= '0;
            r_rd_cnt   <= '0;
            r_rel_len  <= '0;
            r_ram_v    <= 1'b0;
            r_ram_last <= 1'b0;
            r_data     <= '0;
            r_dv       <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rd_cnt  <= w_fifo_head;
                r_rel_len <= w_fifo_head;
            end
            if (w_issue) begin
                r_rd_ptr <= AW'(next_ptr(32'(r_rd_ptr), pDEPTH_RAM));
                r_rd_cnt <= r_rd_cnt - 1'b1;
            end
            r_ram_v    <= w_issue;
            r_ram_last <= w_issue_last;
            r_dv       <= r_ram_v;
            r_last     <= r_ram_last;
            r_data     <= r_ram_v ? w_ram_q : '0;
        end
    end

    // Space is returned on the same edge that registers o_last.
    assign w_release = r_ram_last;

    assign o_data      = r_data;
    assign o_dv        = r_dv;
    assign o_last      = r_last;
    assign o_rd_busy   = (r_rd_state != R_IDLE) || r_dv;
    assign o_pkt_avail = !w_fifo_empty;
    assign o_pkt_len   = w_fifo_empty ? '0 : w_fifo_head;
    assign o_drop_err  = r_drop_err;
    assign o_drop_len  = r_drop_len;
    assign o_drop_ovf  = r_drop_ovf;

endmodule

// File: tb/tb_packet_buffer_mem.sv
// Randomized self-checking bench for packet_buffer_mem against a queue-based packet model.
module tb_packet_buffer_mem;

    localparam int DW    = 8;
    localparam int MINL  = 64;
    localparam int MAXL  = 1536;
    localparam int DEPTH = 3072;
    localparam int FD    = 48;
    localparam int LW    = 11;

    localparam int C_OK  = 0;
    localparam int C_ERR = 1;
    localparam int C_OVF = 2;
    localparam int C_LEN = 3;

    logic          iclk = 1'b0;
    logic          i_rst = 1'b1;
    logic          idv = 1'b0;
    logic [DW-1:0] irx_d = '0;
    logic          i_error = 1'b0;
    logic          i_rd_start = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_dv;
    logic          o_last;
    logic          o_pkt_avail;
    logic [LW-1:0] o_pkt_len;
    logic          o_rd_busy;
    logic          o_drop_err;
    logic          o_drop_len;
    logic          o_drop_ovf;

    always #5 iclk = ~iclk;

    packet_buffer_mem #(
        .pDATA_WIDTH        (DW),
        .pMIN_PACKET_LENGTH (MINL),
        .pMAX_PACKET_LENGTH (MAXL),
        .pDEPTH_RAM         (DEPTH),
        .pFIFO_DEPTH        (FD),
        .pLEN_WIDTH         (LW)
    ) dut (
        .iclk        (iclk),
        .i_rst       (i_rst),
        .idv         (idv),
        .irx_d       (irx_d),
        .i_error     (i_error),
        .i_rd_start  (i_rd_start),
        .o_data      (o_data),
        .o_dv        (o_dv),
        .o_last      (o_last),
        .o_pkt_avail (o_pkt_avail),
        .o_pkt_len   (o_pkt_len),
        .o_rd_busy   (o_rd_busy),
        .o_drop_err  (o_drop_err),
        .o_drop_len  (o_drop_len),
        .o_drop_ovf  (o_drop_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_err  = 0;
    int cnt_len  = 0;
    int cnt_ovf  = 0;
    logic avail_at_check;

    // Reference model: committed packet lengths and their words, in order.
    int         q_len[$];
    logic [7:0] q_data[$];
    logic [7:0] frm[$];

    always @(negedge iclk) begin
        if (o_drop_err) cnt_err++;
        if (o_drop_len) cnt_len++;
        if (o_drop_ovf) cnt_ovf++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    function automatic int used_words();
        int s = 0;
        foreach (q_len[k]) s += q_len[k];
        return s;
    endfunction

    // Outcome of a frame from the buffer rules: per-word err/ovf/len, then end-of-frame checks.
    function automatic int predict(input int len, input int errpos, input int used, input int fcnt);
        for (int i = 0; i < len; i++) begin
            if (i == errpos) return C_ERR;
            if (used + i == DEPTH) return C_OVF;
            if (i == MAXL) return C_LEN;
        end
        if (errpos == len) return C_ERR;
        if (fcnt == FD) return C_OVF;
        if (len < MINL) return C_LEN;
        return C_OK;
    endfunction

    task automatic build_frame(input int len, input bit incr);
        frm.delete();
        for (int i = 0; i < len; i++) begin
            frm.push_back(incr ? 8'(i) : 8'($urandom));
        end
    endtask

    // errpos == len raises i_error in the cycle after idv falls.
    task automatic send_words(input int len, input int errpos);
        for (int i = 0; i < len; i++) begin
            idv = 1'b1;
            irx_d = frm[i];
            i_error = (i == errpos);
            tick();
        end
        idv = 1'b0;
        irx_d = '0;
        i_error = (errpos == len);
        tick();
        avail_at_check = o_pkt_avail;
        tick();
        i_error = 1'b0;
    endtask

    task automatic commit_model(input int len);
        q_len.push_back(len);
        for (int i = 0; i < len; i++) q_data.push_back(frm[i]);
    endtask

    task automatic check_head();
        check_val("pkt_avail", o_pkt_avail, q_len.size() != 0);
        check_val("pkt_len", o_pkt_len, (q_len.size() != 0) ? q_len[0] : 0);
    endtask

    task automatic check_drops(input int exp_c, input int e0, input int l0, input int o0);
        check_val("drop_err", cnt_err - e0, exp_c == C_ERR);
        check_val("drop_len", cnt_len - l0, exp_c == C_LEN);
        check_val("drop_ovf", cnt_ovf - o0, exp_c == C_OVF);
    endtask

    task automatic frame_txn(input int len, input int errpos, input bit incr);
        int exp_c, e0, l0, o0;
        build_frame(len, incr);
        exp_c = predict(len, errpos, used_words(), q_len.size());
        e0 = cnt_err; l0 = cnt_len; o0 = cnt_ovf;
        send_words(len, errpos);
        repeat (3) tick();
        check_drops(exp_c, e0, l0, o0);
        if (exp_c == C_OK) commit_model(len);
        check_head();
    endtask

    task automatic read_pkt();
        int L, n, cyc, first;
        if (q_len.size() == 0) return;
        L = q_len.pop_front();
        check_val("rd_head_len", o_pkt_len, L);
        i_rd_start = 1'b1;
        tick();
        i_rd_start = 1'b0;
        check_val("rd_busy_rise", o_rd_busy, 1);
        check_val("rd_pkt_len_next", o_pkt_len, (q_len.size() != 0) ? q_len[0] : 0);
        n = 0; cyc = 0; first = -1;
        while (n < L && cyc < L + 10) begin
            tick();
            cyc++;
            if (o_dv) begin
                logic [7:0] e;
                e = q_data.pop_front();
                if (first < 0) first = cyc;
                check_val("rd_data", o_data, e);
                check_val("rd_last", o_last, n == L - 1);
                n++;
            end
        end
        check_val("rd_first_lat", first, 2);
        check_val("rd_words", n, L);
        for (int k = n; k < L; k++) void'(q_data.pop_front());
        tick();
        check_val("rd_busy_fall", o_rd_busy, 0);
    endtask

    task automatic check_outs_zero(input string tag);
        check_val({tag, "_data"}, o_data, 0);
        check_val({tag, "_dv"}, o_dv, 0);
        check_val({tag, "_last"}, o_last, 0);
        check_val({tag, "_avail"}, o_pkt_avail, 0);
        check_val({tag, "_len"}, o_pkt_len, 0);
        check_val({tag, "_busy"}, o_rd_busy, 0);
        check_val({tag, "_derr"}, o_drop_err, 0);
        check_val({tag, "_dlen"}, o_drop_len, 0);
        check_val({tag, "_dovf"}, o_drop_ovf, 0);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        tick();
        check_outs_zero("rst");
        i_rst = 1'b0;
        q_len.delete();
        q_data.delete();
        tick();
    endtask

    initial begin
        int exp_c, e0, l0, o0;

        do_reset();

        // Good 64-word frame with incrementing data and exact commit timing.
        build_frame(64, 1'b1);
        send_words(64, -1);
        check_val("commit_pre", avail_at_check, 0);
        check_val("commit_avail", o_pkt_avail, 1);
        check_val("commit_len", o_pkt_len, 64);
        commit_model(64);
        repeat (2) tick();
        read_pkt();

        // Errored frame then a good frame stored from the rolled-back address.
        frame_txn(100, 49, 1'b0);
        frame_txn(70, -1, 1'b0);
        read_pkt();

        // Runt and oversize frames.
        frame_txn(63, -1, 1'b0);
        frame_txn(1537, -1, 1'b0);

        // RAM full, overflow, then a commit across the wrap point.
        frame_txn(1536, -1, 1'b0);
        frame_txn(1536, -1, 1'b0);
        frame_txn(64, -1, 1'b0);
        read_pkt();
        frame_txn(1536, -1, 1'b0);
        read_pkt();
        read_pkt();

        // Fill the length queue with minimum frames.
        for (int k = 0; k < FD + 1; k++) frame_txn(MINL, -1, 1'b0);
        for (int k = 0; k < FD; k++) read_pkt();

        // Randomized mix of frames, errors (including end-of-frame error) and reads.
        for (int k = 0; k < 30; k++) begin
            if (q_len.size() != 0 && $urandom_range(0, 2) == 0) begin
                read_pkt();
            end else begin
                int len, ep;
                len = $urandom_range(40, 220);
                ep = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
                frame_txn(len, ep, 1'b0);
                repeat ($urandom_range(0, 3)) tick();
            end
        end
        while (q_len.size() != 0) read_pkt();

        // Commit of B on the same edge as o_last of A, then an exact-fill boundary.
        do_reset();
        frame_txn(64, -1, 1'b0);
        build_frame(64, 1'b0);
        exp_c = predict(64, -1, used_words(), q_len.size() - 1);
        e0 = cnt_err; l0 = cnt_len; o0 = cnt_ovf;
        fork
            read_pkt();
            send_words(64, -1);
        join
        repeat (3) tick();
        check_drops(exp_c, e0, l0, o0);
        if (exp_c == C_OK) commit_model(64);
        check_head();
        frame_txn(1536, -1, 1'b0);
        frame_txn(DEPTH - 64 - 1536, -1, 1'b0);
        frame_txn(64, -1, 1'b0);
        read_pkt();

        // Reset mid-stream.
        i_rd_start = 1'b1;
        tick();
        i_rd_start = 1'b0;
        repeat (10) tick();
        i_rst = 1'b1;
        tick();
        check_outs_zero("rst_mid");
        i_rst = 1'b0;
        q_len.delete();
        q_data.delete();
        tick();

        // Reset mid-frame: remainder of the frame is discarded silently.
        e0 = cnt_err; l0 = cnt_len; o0 = cnt_ovf;
        for (int i = 0; i < 10; i++) begin
            idv = 1'b1; irx_d = 8'($urandom); tick();
        end
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        for (int i = 0; i < 80; i++) begin
            idv = 1'b1; irx_d = 8'($urandom); tick();
        end
        idv = 1'b0;
        repeat (4) tick();
        check_drops(C_OK, e0, l0, o0);
        check_head();
        frame_txn(80, -1, 1'b0);
        read_pkt();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
